// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the four-digit multiplexed seven-segment driver.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Segment patterns are active-low with bit order {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  // Number of multiplexed digits and the width of the scan index.
  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [6:0]       seg_t;

  // Special patterns.
  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b0111111;

  // Decimal digit patterns.
  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;

  // Active-low one-hot digit enable for a scan index. Index 0 is the
  // leftmost digit and is driven by the most significant enable bit.
  function automatic logic [NUM_DIGITS-1:0] digit_enable(input idx_t idx);
    logic [NUM_DIGITS-1:0] en;
    en = '1;
    en[NUM_DIGITS-1-int'(idx)] = 1'b0;
    return en;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// BCD nibble to active-low seven-segment pattern, with a forced-blank input.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   nibble  - BCD digit to show; values 10..15 are shown as a dash
//   blank   - when high the output is all segments off, regardless of nibble
//   pattern - active-low segments {g,f,e,d,c,b,a}
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_DASH;
    if (blank) begin
      pattern = SEG_BLANK;
    end else begin
      case (nibble)
        4'd0:    pattern = SEG_0;
        4'd1:    pattern = SEG_1;
        4'd2:    pattern = SEG_2;
        4'd3:    pattern = SEG_3;
        4'd4:    pattern = SEG_4;
        4'd5:    pattern = SEG_5;
        4'd6:    pattern = SEG_6;
        4'd7:    pattern = SEG_7;
        4'd8:    pattern = SEG_8;
        4'd9:    pattern = SEG_9;
        default: pattern = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed four-digit seven-segment driver with a one-deep load buffer.
// Latency: digit/segments are registered, updating one cycle after each prescaler tick.
// Backpressure: load_ready low while a value is pending; it frees only at a frame wrap.
//
// Ports:
//   clock, reset  - rising-edge clock, asynchronous active-high reset
//   value_in      - four BCD nibbles, [15:12] is the leftmost digit
//   load_valid    - value_in offered this cycle
//   load_ready    - pending buffer empty; a valid on this cycle is accepted
//   blank_lz      - blank zero nibbles to the left of the first nonzero one
//   digit         - active-low one-hot digit enable, digit[3] is the leftmost digit
//   segments      - active-low {g,f,e,d,c,b,a}
//   frame_done    - one-cycle pulse with the digit-0 update that follows a wrap
//
// CLK_DIV sets the number of cycles each digit stays lit and must be at least 2.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        blank_lz,
  output logic [3:0]  digit,
  output logic [6:0]  segments,
  output logic        frame_done
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  // --------------------------------------------------------------------------
  // Prescaler: counts 0..CLK_DIV-1, tick on the terminal count.
  // --------------------------------------------------------------------------
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  assign tick = (pre_cnt == PRE_W'(CLK_DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Scan index. The index names the digit that the next tick will light, so
  // the first tick after reset lights digit 0 and the index moves on to 1.
  // --------------------------------------------------------------------------
  idx_t scan_idx;
  logic last_digit;
  logic frame_wrap;

  assign last_digit = (scan_idx == idx_t'(NUM_DIGITS - 1));
  assign frame_wrap = tick && last_digit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_idx <= '0;
    end else if (tick) begin
      scan_idx <= last_digit ? '0 : scan_idx + idx_t'(1);
    end
  end

  // Remembers that at least one full frame has been scanned, so the very first
  // digit-0 update after reset (which is not a wrap) does not pulse frame_done.
  logic wrapped_once;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrapped_once <= 1'b0;
    end else if (frame_wrap) begin
      wrapped_once <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Load path: one pending slot in front of the display register.
  // The display register only changes on the wrap tick, i.e. on the same edge
  // that lights digit 3, so every frame shows a single value. A transfer needs
  // the slot full and an accept needs it empty, so the two never collide.
  // --------------------------------------------------------------------------
  logic [VAL_W-1:0] disp_val;
  logic [VAL_W-1:0] pend_val;
  logic             pend_full;

  assign load_ready = ~pend_full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_val  <= '0;
      pend_val  <= '0;
      pend_full <= 1'b0;
    end else if (frame_wrap && pend_full) begin
      disp_val  <= pend_val;
      pend_full <= 1'b0;
    end else if (load_valid && !pend_full) begin
      pend_val  <= value_in;
      pend_full <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Current nibble and leading-zero blanking.
  // A digit is a leading zero when it and every digit to its left are zero.
  // The rightmost digit is always shown so an all-zero value reads "0".
  // --------------------------------------------------------------------------
  logic [3:0] cur_nibble;
  logic       seen_nonzero;
  logic       cur_blank;
  seg_t       cur_pattern;

  always_comb begin
    cur_nibble   = '0;
    seen_nonzero = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_t'(i) == scan_idx) begin
        cur_nibble = disp_val[VAL_W-1-4*i -: 4];
      end
      if ((i <= int'(scan_idx)) && (disp_val[VAL_W-1-4*i -: 4] != 4'd0)) begin
        seen_nonzero = 1'b1;
      end
    end
    cur_blank = blank_lz && !seen_nonzero && !last_digit;
  end

  seven_seg_decoder u_decoder (
    .nibble  (cur_nibble),
    .blank   (cur_blank),
    .pattern (cur_pattern)
  );

  // --------------------------------------------------------------------------
  // Output registers: digit, segments and frame_done move together on the
  // edge that sees tick, so the panel never shows one digit's segments on
  // another digit's enable.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digit      <= '1;
      segments   <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (tick) begin
        digit      <= digit_enable(scan_idx);
        segments   <= cur_pattern;
        frame_done <= (scan_idx == '0) && wrapped_once;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver with CLK_DIV = 4.
// Latency: n/a.
// Backpressure: n/a.
module tb_seven_seg_scan_driver;

  localparam int CLK_DIV = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value_in = '0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic        blank_lz = 1'b0;
  logic [3:0]  digit;
  logic [6:0]  segments;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  seven_seg_scan_driver #(.CLK_DIV(CLK_DIV)) dut (
    .clock      (clock),
    .reset      (reset),
    .value_in   (value_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .blank_lz   (blank_lz),
    .digit      (digit),
    .segments   (segments),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // --------------------------------------------------------------------------
  // Reference model. Counts rising edges since reset; edge number k is a tick
  // when k is a multiple of CLK_DIV, and tick number n lights digit (n-1) mod 4.
  // The tick lighting digit 3 ends a frame and promotes the pending value.
  // --------------------------------------------------------------------------
  function automatic logic [6:0] ref_seg(input logic [15:0] v, input int i, input logic blz);
    int         sh;
    logic [3:0] nib;
    sh  = 4 * (3 - i);
    nib = 4'((v >> sh) & 16'hF);
    // (v >> sh) == 0 means this digit and everything left of it is zero.
    if (blz && i != 3 && (v >> sh) == 16'h0) return 7'b1111111;
    case (nib)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  int          m_k;
  int          kn, n_m, i_m;
  logic        tick_m;
  logic [15:0] m_disp, m_pend;
  logic        m_full;
  logic [3:0]  exp_digit;
  logic [6:0]  exp_seg;
  logic        exp_fd;

  assign kn     = m_k + 1;
  assign tick_m = (kn % CLK_DIV) == 0;
  assign n_m    = kn / CLK_DIV;
  assign i_m    = (n_m + 3) % 4;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_k <= 0; m_disp <= '0; m_pend <= '0; m_full <= 1'b0;
      exp_digit <= 4'hF; exp_seg <= 7'h7F; exp_fd <= 1'b0;
    end else begin
      m_k    <= kn;
      exp_fd <= tick_m && (i_m == 0) && (n_m > 1);
      if (tick_m) begin
        exp_digit <= ~(4'b1000 >> i_m);
        exp_seg   <= ref_seg(m_disp, i_m, blank_lz);
      end
      if (tick_m && i_m == 3 && m_full) begin
        m_disp <= m_pend; m_full <= 1'b0;
      end else if (load_valid && !m_full) begin
        m_pend <= value_in; m_full <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus / capture helpers (no comparisons inside).
  // --------------------------------------------------------------------------
  // Waits for frame_done, then samples the four digit updates of that frame.
  task automatic show_frame(output logic [27:0] got, output logic ok);
    int g;
    g = 0; got = '0;
    do begin @(negedge clock); g++; end while (frame_done !== 1'b1 && g < 80);
    ok = (frame_done === 1'b1);
    if (!ok) return;
    got[27:21] = segments; repeat (CLK_DIV) @(negedge clock);
    got[20:14] = segments; repeat (CLK_DIV) @(negedge clock);
    got[13:7]  = segments; repeat (CLK_DIV) @(negedge clock);
    got[6:0]   = segments;
  endtask

  // Offers v, waits for it to reach the display, then captures the next frame.
  task automatic load_and_show(input logic [15:0] v, output logic [27:0] got, output logic ok);
    int g;
    ok = 1'b0; got = '0;
    g = 0;
    @(negedge clock);
    while (load_ready !== 1'b1 && g < 80) begin @(negedge clock); g++; end
    if (load_ready !== 1'b1) return;
    value_in = v; load_valid = 1'b1;
    @(negedge clock);
    load_valid = 1'b0;
    g = 0;
    while (load_ready !== 1'b1 && g < 80) begin @(negedge clock); g++; end
    if (load_ready !== 1'b1) return;
    show_frame(got, ok);
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    int cnt;
    reset = 1'b1; load_valid = 1'b0; value_in = '0; blank_lz = 1'b0;
    repeat (3) @(negedge clock);
    tests++; if (digit !== 4'b1111) begin fails++; $display("FAIL reset_digit: got %b want 1111", digit); end
    tests++; if (segments !== 7'b1111111) begin fails++; $display("FAIL reset_segments: got %b want 1111111", segments); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL reset_load_ready: got %b want 1", load_ready); end
    reset = 1'b0;
    cnt = 0;
    do begin @(negedge clock); cnt++; end while (digit === 4'b1111 && cnt < 12);
    tests++; if (cnt != CLK_DIV || digit !== 4'b0111) begin
      fails++; $display("FAIL first_tick: got digit %b after %0d cycles want 0111 after %0d", digit, cnt, CLK_DIV);
    end
  endtask

  task automatic test_scan();
    logic [3:0] seq [4];
    logic [3:0] prev;
    int last, nchg, fd_last, fd_cnt;
    seq[0] = 4'b1011; seq[1] = 4'b1101; seq[2] = 4'b1110; seq[3] = 4'b0111;
    prev = digit; last = 0; nchg = 0; fd_last = -1; fd_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (digit !== prev) begin
        tests++;
        if (digit !== seq[nchg % 4] || c - last != CLK_DIV) begin
          fails++; $display("FAIL scan_step: got %b at gap %0d want %b at gap %0d", digit, c - last, seq[nchg % 4], CLK_DIV);
        end
        nchg++; last = c; prev = digit;
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        tests++;
        if ((fd_last >= 0 && c - fd_last != 16) || digit !== 4'b0111) begin
          fails++; $display("FAIL frame_done_align: got gap %0d digit %b want gap 16 digit 0111", c - fd_last, digit);
        end
        fd_last = c;
      end
      tests++; if (frame_done !== exp_fd) begin fails++; $display("FAIL scan_frame_done: got %b want %b", frame_done, exp_fd); end
    end
    tests++; if (nchg != 10) begin fails++; $display("FAIL scan_count: got %0d steps want 10", nchg); end
    tests++; if (fd_cnt != 2) begin fails++; $display("FAIL frame_done_count: got %0d want 2", fd_cnt); end
  endtask

  task automatic test_load_1234();
    logic [27:0] got, want; logic ok;
    blank_lz = 1'b0;
    want = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    load_and_show(16'h1234, got, ok);
    tests++; if (!ok) begin fails++; $display("FAIL load_1234_timeout: got timeout want frame"); end
    for (int d = 0; d < 4; d++) begin
      tests++;
      if (got[27-7*d -: 7] !== want[27-7*d -: 7]) begin
        fails++; $display("FAIL load_1234 digit%0d: got %b want %b", d, got[27-7*d -: 7], want[27-7*d -: 7]);
      end
    end
  endtask

  task automatic test_blank_lz();
    logic [27:0] got, want; logic ok;
    blank_lz = 1'b1;
    want = {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000};
    load_and_show(16'h0050, got, ok);
    tests++; if (!ok) begin fails++; $display("FAIL blank_0050_timeout: got timeout want frame"); end
    for (int d = 0; d < 4; d++) begin
      tests++;
      if (got[27-7*d -: 7] !== want[27-7*d -: 7]) begin
        fails++; $display("FAIL blank_0050 digit%0d: got %b want %b", d, got[27-7*d -: 7], want[27-7*d -: 7]);
      end
    end
    want = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};
    load_and_show(16'h0000, got, ok);
    tests++; if (!ok) begin fails++; $display("FAIL blank_0000_timeout: got timeout want frame"); end
    for (int d = 0; d < 4; d++) begin
      tests++;
      if (got[27-7*d -: 7] !== want[27-7*d -: 7]) begin
        fails++; $display("FAIL blank_0000 digit%0d: got %b want %b", d, got[27-7*d -: 7], want[27-7*d -: 7]);
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_dash();
    logic [27:0] got, want; logic ok;
    blank_lz = 1'b0;
    want = {7'b1111001, 7'b0100100, 7'b0111111, 7'b0111111};
    load_and_show(16'h12AF, got, ok);
    tests++; if (!ok) begin fails++; $display("FAIL dash_timeout: got timeout want frame"); end
    for (int d = 0; d < 4; d++) begin
      tests++;
      if (got[27-7*d -: 7] !== want[27-7*d -: 7]) begin
        fails++; $display("FAIL dash_12af digit%0d: got %b want %b", d, got[27-7*d -: 7], want[27-7*d -: 7]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [27:0] got, want; logic ok; logic [3:0] prev; int g;
    blank_lz = 1'b0;
    want = {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};
    g = 0;
    do begin @(negedge clock); g++; end while (frame_done !== 1'b1 && g < 80);
    tests++; if (frame_done !== 1'b1) begin fails++; $display("FAIL busy_sync: got no frame_done want pulse"); end
    @(negedge clock);
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL busy_ready_idle: got %b want 1", load_ready); end
    value_in = 16'h5678; load_valid = 1'b1;
    @(negedge clock);
    tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL busy_ready_drop: got %b want 0", load_ready); end
    value_in = 16'h9999;
    prev = digit; g = 0;
    while (load_ready !== 1'b1 && g < 80) begin prev = digit; @(negedge clock); g++; end
    load_valid = 1'b0;
    tests++;
    if (load_ready !== 1'b1 || digit !== 4'b1110 || prev !== 4'b1101) begin
      fails++; $display("FAIL busy_ready_rise: got ready %b digit %b prev %b want 1 1110 1101", load_ready, digit, prev);
    end
    for (int f = 0; f < 2; f++) begin
      show_frame(got, ok);
      tests++; if (!ok) begin fails++; $display("FAIL busy_frame_timeout: got timeout want frame"); end
      for (int d = 0; d < 4; d++) begin
        tests++;
        if (got[27-7*d -: 7] !== want[27-7*d -: 7]) begin
          fails++; $display("FAIL busy_frame%0d digit%0d: got %b want %b", f, d, got[27-7*d -: 7], want[27-7*d -: 7]);
        end
      end
    end
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL busy_ready_end: got %b want 1", load_ready); end
  endtask

  task automatic test_reset_midframe();
    logic [27:0] got; logic ok; int g;
    blank_lz = 1'b0;
    g = 0;
    do begin @(negedge clock); g++; end while (digit !== 4'b1011 && g < 80);
    tests++; if (load_ready !== 1'b1 || digit !== 4'b1011) begin
      fails++; $display("FAIL midreset_setup: got ready %b digit %b want 1 1011", load_ready, digit);
    end
    value_in = 16'h8888; load_valid = 1'b1;
    @(negedge clock);
    load_valid = 1'b0;
    tests++; if (load_ready !== 1'b0) begin fails++; $display("FAIL midreset_pending: got %b want 0", load_ready); end
    #2 reset = 1'b1;
    #1;
    tests++; if (digit !== 4'b1111) begin fails++; $display("FAIL midreset_digit: got %b want 1111", digit); end
    tests++; if (segments !== 7'b1111111) begin fails++; $display("FAIL midreset_segments: got %b want 1111111", segments); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL midreset_frame_done: got %b want 0", frame_done); end
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready: got %b want 1", load_ready); end
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      tests++; if (segments === 7'b0000000) begin fails++; $display("FAIL midreset_leak: got %b want not 0000000", segments); end
      tests++; if (segments !== exp_seg || digit !== exp_digit) begin
        fails++; $display("FAIL midreset_scan: got %b/%b want %b/%b", digit, segments, exp_digit, exp_seg);
      end
    end
    show_frame(got, ok);
    tests++; if (!ok || got !== {4{7'b1000000}}) begin
      fails++; $display("FAIL midreset_frame: got %h want %h", got, {4{7'b1000000}});
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      tests++; if (digit !== exp_digit) begin fails++; $display("FAIL rand_digit c%0d: got %b want %b", c, digit, exp_digit); end
      tests++; if (segments !== exp_seg) begin fails++; $display("FAIL rand_segments c%0d: got %b want %b", c, segments, exp_seg); end
      tests++; if (frame_done !== exp_fd) begin fails++; $display("FAIL rand_frame_done c%0d: got %b want %b", c, frame_done, exp_fd); end
      tests++; if (load_ready !== !m_full) begin fails++; $display("FAIL rand_ready c%0d: got %b want %b", c, load_ready, !m_full); end
      // Bias nibbles towards zero so leading-zero blanking is exercised.
      for (int d = 0; d < 4; d++) begin
        v[4*d +: 4] = ($urandom % 8 < 3) ? 4'd0 : 4'($urandom % 16);
      end
      value_in   = v;
      load_valid = ($urandom % 4) == 0;
      if (c % 97 == 0) blank_lz = 1'($urandom % 2);
    end
    load_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_1234();
    test_blank_lz();
    test_dash();
    test_busy_ignore();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 Parameter CLK_DIV, default 50000, SHALL set the number of clock cycles each digit is lit (minimum 2).
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 value_in  input  16  four BCD nibbles; [15:12] is digit 0 (leftmost), [3:0] is digit 3 (rightmost).
REQ-006 load_valid  input  1  value_in is offered this cycle.
REQ-007 load_ready  output  1  pending buffer is empty and can accept value_in.
REQ-008 blank_lz  input  1  when high, leading zeros are blanked.
REQ-009 digit  output  4  one-hot active-low digit enable; digit[3] drives digit 0 (leftmost), digit[0] drives digit 3.
REQ-010 segments  output  7  active-low segment pattern, bit order {g,f,e,d,c,b,a}.
REQ-011 frame_done  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Function
REQ-012 The prescaler SHALL count 0..CLK_DIV-1 and wrap; tick SHALL be high on the cycle the count equals CLK_DIV-1.
REQ-013 On each tick the digit index SHALL advance 0->1->2->3->0.
REQ-014 digit and segments SHALL be registered and SHALL update together on the cycle after tick (latency 1 from tick).
REQ-015 For index i, digit SHALL be all ones except bit 3-i: index 0 gives 4'b0111, index 3 gives 4'b1110.
REQ-016 BCD 0-9 SHALL map to standard patterns (0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000); nibbles A-F SHALL show a dash, 7'b0111111.
REQ-017 With blank_lz high, every zero nibble left of the first nonzero nibble SHALL show 7'b1111111; digit 3 SHALL never be blanked.
REQ-018 Handshake: when load_valid and load_ready are both high on a rising edge, value_in SHALL be captured into the pending register and load_ready SHALL drop on the next cycle.
REQ-019 A full pending register SHALL move into the display register on the tick that wraps index 3 to 0, and load_ready SHALL rise on the following cycle.
REQ-020 A value accepted on the same cycle as a wrap SHALL stay pending until the next wrap.
REQ-021 load_valid while load_ready is low SHALL be ignored.
REQ-022 frame_done SHALL pulse for one cycle, aligned with the digit output update for index 0.
REQ-023 The display register SHALL change only at frame boundaries, so a frame never mixes two values.

Reset
REQ-024 Reset SHALL set: prescaler 0, index 0, digit 4'b1111, segments 7'b1111111, display register 16'h0000, pending empty, load_ready 1, frame_done 0.
REQ-025 Reset asserted mid-frame SHALL immediately force the REQ-024 values and discard any pending value.
REQ-026 After reset releases, the first tick SHALL light digit 0.

Structure
REQ-027 Package seven_seg_pkg SHALL hold: segment constants SEG_BLANK, SEG_DASH and the digit 0-9 patterns; constant NUM_DIGITS = 4; the digit-index width.
REQ-028 The BCD-to-segment decode SHALL be a separate combinational sub-module, seven_seg_decoder, which takes a nibble and a blank flag and returns a 7-bit pattern.

Verification (bench CLK_DIV = 4)
REQ-029 Release reset and idle -> digit goes 0111, 1011, 1101, 1110, 0111, with each step 4 cycles apart; frame_done pulses once every 16 cycles.
REQ-030 Load 16'h1234 with blank_lz=0 -> after the next wrap, segments are 1111001, 0100100, 0110000, 0011001 for digits 0-3.
REQ-031 Load 16'h0050 with blank_lz=1 -> digits 0 and 1 are blank, digit 2 is 0010010, digit 3 is 1000000; load 16'h0000 -> only digit 3 shows 1000000.
REQ-032 Load 16'h12AF -> digits 2 and 3 show 0111111.
REQ-033 Load A mid-frame, then present B while load_ready=0 -> B is ignored; A is displayed from the next frame; load_ready rises the cycle after the wrap.
REQ-034 Assert reset while index is 2 and a value is pending -> all outputs match REQ-024 immediately; the pending value is never displayed.
